// File: rtl/ascii_freq_parser.sv
// ascii_freq_parser
// Turns a line of ASCII decimal digits into a binary frequency. One byte moves
// per RX_VALID/RX_READY handshake. CR or LF commits the line, ESC abandons it,
// and anything malformed is swallowed up to the next terminator and then
// reported with a single ERROR pulse. FREQ holds the last good value.
// Digits are most significant first. With SCALE_KHZ=1 they are read as kHz
// and scaled to Hz on commit.
module ascii_freq_parser #(
    parameter int MAX_DIGITS = 5,    // digits allowed per line, 1..5
    parameter bit SCALE_KHZ  = 1'b1  // 1: value*1000 on commit, 0: raw value
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic [31:0] FREQ,
    output logic        FREQ_VALID,
    output logic        ERROR,
    output logic [2:0]  DIGIT_COUNT
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCUM   = 3'd1,
        ST_DISCARD = 3'd2,
        ST_SCALE   = 3'd3,
        ST_COMMIT  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CH_DIGIT   = 2'd0,
        CH_TERM    = 2'd1,
        CH_ESC     = 2'd2,
        CH_ILLEGAL = 2'd3
    } char_class_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [16:0] acc_q, acc_d;          // 17 bits is enough for 99999
    logic [2:0]  count_q, count_d;
    logic [31:0] result_q, result_d;    // scaled value, staged for COMMIT
    logic [31:0] freq_q, freq_d;
    logic        freq_valid_q, freq_valid_d;
    logic        error_q, error_d;
    logic        ready_en_q;            // keeps RX_READY low until the first edge after reset

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    char_class_t char_class;
    logic [3:0]  digit_val;
    logic [16:0] acc_mac;
    logic [31:0] scaled_value;
    logic        rx_xfer;

    // Decode the incoming byte into one of the four character classes
    always_comb begin
        char_class = CH_ILLEGAL;
        if (RX_DATA >= 8'h30 && RX_DATA <= 8'h39) begin
            char_class = CH_DIGIT;
        end else if (RX_DATA == 8'h0D || RX_DATA == 8'h0A) begin
            char_class = CH_TERM;
        end else if (RX_DATA == 8'h1B) begin
            char_class = CH_ESC;
        end
    end

    // For bytes 0x30..0x39 the low nibble is exactly RX_DATA - 0x30
    assign digit_val = RX_DATA[3:0];

    // acc*10 + digit built from shifts; the digit limit keeps it within 17 bits
    always_comb begin
        acc_mac = (acc_q << 3) + (acc_q << 1) + {13'd0, digit_val};
    end

    generate
        if (SCALE_KHZ) begin : g_scale_khz
            logic [26:0] acc_wide;
            logic [26:0] acc_x1000;
            // acc*1000 = acc*1024 - acc*16 - acc*8; 99999*1000 fits in 27 bits
            always_comb begin
                acc_wide     = {10'd0, acc_q};
                acc_x1000    = (acc_wide << 10) - (acc_wide << 4) - (acc_wide << 3);
                scaled_value = {5'd0, acc_x1000};
            end
        end else begin : g_scale_raw
            // Unscaled mode passes the accumulator straight through
            always_comb begin
                scaled_value = {15'd0, acc_q};
            end
        end
    endgenerate

    // Ready depends only on state, never on RX_VALID, so upstream sees no loop
    always_comb begin
        RX_READY = ready_en_q &&
                   (state_q == ST_IDLE || state_q == ST_ACCUM || state_q == ST_DISCARD);
    end

    assign rx_xfer = RX_VALID && RX_READY;

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    // Line parser: accumulate digits, route bad lines to DISCARD, commit on terminator
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        result_d     = result_q;
        freq_d       = freq_q;
        freq_valid_d = 1'b0;
        error_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_xfer) begin
                    unique case (char_class)
                        CH_DIGIT: begin
                            acc_d   = {13'd0, digit_val};
                            count_d = 3'd1;
                            state_d = ST_ACCUM;
                        end
                        CH_ILLEGAL: begin
                            state_d = ST_DISCARD;
                        end
                        // Empty lines, the LF of a CR/LF pair and a bare ESC are no-ops
                        default: begin
                        end
                    endcase
                end
            end

            ST_ACCUM: begin
                if (rx_xfer) begin
                    unique case (char_class)
                        CH_DIGIT: begin
                            if (count_q == MAX_CNT) begin
                                // Too many digits: the line can no longer be valid
                                acc_d   = '0;
                                count_d = '0;
                                state_d = ST_DISCARD;
                            end else begin
                                acc_d   = acc_mac;
                                count_d = count_q + 3'd1;
                            end
                        end
                        CH_TERM: begin
                            // Keep acc for scaling; the count display goes back to 0
                            count_d = '0;
                            state_d = ST_SCALE;
                        end
                        CH_ESC: begin
                            acc_d   = '0;
                            count_d = '0;
                            state_d = ST_IDLE;
                        end
                        default: begin
                            acc_d   = '0;
                            count_d = '0;
                            state_d = ST_DISCARD;
                        end
                    endcase
                end
            end

            ST_DISCARD: begin
                if (rx_xfer) begin
                    if (char_class == CH_TERM) begin
                        error_d = 1'b1;
                        acc_d   = '0;
                        count_d = '0;
                        state_d = ST_IDLE;
                    end else if (char_class == CH_ESC) begin
                        // The user cancelled the line, so there is nothing to report
                        acc_d   = '0;
                        count_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_SCALE: begin
                result_d = scaled_value;
                state_d  = ST_COMMIT;
            end

            ST_COMMIT: begin
                freq_d       = result_q;
                freq_valid_d = 1'b1;
                acc_d        = '0;
                count_d      = '0;
                state_d      = ST_IDLE;
            end

            default: begin
                acc_d   = '0;
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // State, datapath and output pulse registers with asynchronous reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            count_q      <= '0;
            result_q     <= '0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            error_q      <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            result_q     <= result_d;
            freq_q       <= freq_d;
            freq_valid_q <= freq_valid_d;
            error_q      <= error_d;
            ready_en_q   <= 1'b1;
        end
    end

    assign FREQ        = freq_q;
    assign FREQ_VALID  = freq_valid_q;
    assign ERROR       = error_q;
    assign DIGIT_COUNT = count_q;

endmodule
